// File: rtl/alu_seq_n_if.sv
// Operand-issue / result-writeback bundle for the N-bit sequential ALU.
// The master is the issue logic; the slave is the ALU itself.
interface alu_seq_n_if #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               cin;
    logic [3:0]         sel;
    logic [SHAMT_W-1:0] shamt;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   result;
    logic               cout;
    logic               zero;
    logic               overflow;
    logic               busy;

    modport master (
        output in_valid, a, b, cin, sel, shamt, out_ready,
        input  in_ready, out_valid, result, cout, zero, overflow, busy
    );

    modport slave (
        input  in_valid, a, b, cin, sel, shamt, out_ready,
        output in_ready, out_valid, result, cout, zero, overflow, busy
    );
endinterface

// File: rtl/alu_seq_n.sv
// N-bit sequential ALU: single-cycle arithmetic/logic, one-bit-per-clock shifts,
// valid/ready handshakes on both sides and registered result/flags.
module alu_seq_n #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic        clk,
    input  logic        rst_n,
    alu_seq_n_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [WIDTH-1:0]   result_r;
    logic [WIDTH-1:0]   result_nxt_s;
    logic               cout_r;
    logic               cout_nxt_s;
    logic               overflow_r;
    logic               overflow_nxt_s;
    logic               zero_r;
    logic [SHAMT_W-1:0] count_r;
    logic [SHAMT_W-1:0] count_nxt_s;
    logic [2:0]         mode_r;
    logic [2:0]         mode_nxt_s;
    logic               cin_r;
    logic               cin_nxt_s;

    logic [WIDTH-1:0]   bv_s;
    logic [WIDTH:0]     sum_s;
    logic               ovf_s;
    logic [WIDTH-1:0]   logic_s;
    logic               fill_s;
    logic [WIDTH-1:0]   shifted_s;
    logic               shout_s;

    // Operand B selection, adder and bitwise unit on the live inputs (used at accept)
    always_comb begin
        case (bus.sel[1:0])
            2'b00:   bv_s = {WIDTH{1'b0}};
            2'b01:   bv_s = bus.b;
            2'b10:   bv_s = ~bus.b;
            2'b11:   bv_s = {WIDTH{1'b1}};
            default: bv_s = {WIDTH{1'b0}};
        endcase
        sum_s = {1'b0, bus.a} + {1'b0, bv_s} + {{WIDTH{1'b0}}, bus.cin};
        ovf_s = (bus.a[WIDTH-1] == bv_s[WIDTH-1]) && (sum_s[WIDTH-1] != bus.a[WIDTH-1]);
        case (bus.sel[1:0])
            2'b00:   logic_s = bus.a & bus.b;
            2'b01:   logic_s = bus.a | bus.b;
            2'b10:   logic_s = bus.a ^ bus.b;
            2'b11:   logic_s = ~bus.a;
            default: logic_s = {WIDTH{1'b0}};
        endcase
    end

    // One-position shift step of the result register; mode_r = {left, fill select}
    always_comb begin
        fill_s    = 1'b0;
        shifted_s = result_r;
        shout_s   = 1'b0;
        if (mode_r[2]) begin
            case (mode_r[1:0])
                2'b10:   fill_s = result_r[WIDTH-1];
                2'b11:   fill_s = cin_r;
                default: fill_s = 1'b0;
            endcase
            shifted_s = {result_r[WIDTH-2:0], fill_s};
            shout_s   = result_r[WIDTH-1];
        end else begin
            case (mode_r[1:0])
                2'b01:   fill_s = result_r[WIDTH-1];
                2'b10:   fill_s = result_r[0];
                2'b11:   fill_s = cin_r;
                default: fill_s = 1'b0;
            endcase
            shifted_s = {fill_s, result_r[WIDTH-1:1]};
            shout_s   = result_r[0];
        end
    end

    // Next-state and datapath-load decisions
    always_comb begin
        state_nxt_s    = state_r;
        result_nxt_s   = result_r;
        cout_nxt_s     = cout_r;
        overflow_nxt_s = overflow_r;
        count_nxt_s    = count_r;
        mode_nxt_s     = mode_r;
        cin_nxt_s      = cin_r;
        case (state_r)
            IDLE: begin
                if (bus.in_valid) begin
                    mode_nxt_s  = bus.sel[2:0];
                    cin_nxt_s   = bus.cin;
                    count_nxt_s = bus.shamt;
                    if (!bus.sel[3]) begin
                        state_nxt_s    = HOLD;
                        result_nxt_s   = bus.sel[2] ? logic_s : sum_s[WIDTH-1:0];
                        cout_nxt_s     = sum_s[WIDTH];
                        overflow_nxt_s = bus.sel[2] ? 1'b0 : ovf_s;
                    end else begin
                        state_nxt_s    = (bus.shamt == {SHAMT_W{1'b0}}) ? HOLD : SHIFT;
                        result_nxt_s   = bus.a;
                        cout_nxt_s     = 1'b0;
                        overflow_nxt_s = 1'b0;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SHIFT: begin
                result_nxt_s = shifted_s;
                cout_nxt_s   = shout_s;
                count_nxt_s  = count_r - SHAMT_W'(1'b1);
                if (count_r == SHAMT_W'(1'b1)) begin
                    state_nxt_s = HOLD;
                end else begin
                    state_nxt_s = SHIFT;
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = HOLD;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State and datapath registers; zero tracks whatever value result is loaded with
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            result_r   <= {WIDTH{1'b0}};
            cout_r     <= 1'b0;
            overflow_r <= 1'b0;
            zero_r     <= 1'b0;
            count_r    <= {SHAMT_W{1'b0}};
            mode_r     <= 3'b000;
            cin_r      <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            result_r   <= result_nxt_s;
            cout_r     <= cout_nxt_s;
            overflow_r <= overflow_nxt_s;
            zero_r     <= (result_nxt_s == {WIDTH{1'b0}});
            count_r    <= count_nxt_s;
            mode_r     <= mode_nxt_s;
            cin_r      <= cin_nxt_s;
        end
    end

    // in_ready is gated by rst_n so it reads 0 while reset is held even though state is IDLE
    assign bus.in_ready  = rst_n & (state_r == IDLE);
    assign bus.busy      = (state_r != IDLE);
    assign bus.out_valid = (state_r == HOLD);
    assign bus.result    = result_r;
    assign bus.cout      = cout_r;
    assign bus.zero      = zero_r;
    assign bus.overflow  = overflow_r;
endmodule

// File: tb/tb_alu_seq_n.sv
// Self-checking bench for alu_seq_n (WIDTH = 8): directed steps then random ops
// against a closed-form arithmetic/shift reference model.
module tb_alu_seq_n;
    localparam int W  = 8;
    localparam int SW = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_seq_n_if #(.WIDTH(W), .SHAMT_W(SW)) bus ();
    alu_seq_n #(.WIDTH(W), .SHAMT_W(SW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: result/cout/overflow/latency from plain integer arithmetic
    function automatic void model(input logic [7:0] a, input logic [7:0] b, input logic cin,
                                  input logic [3:0] sel, input int n,
                                  output logic [7:0] r, output logic co, output logic ov,
                                  output int lat);
        logic [7:0] bv;
        logic [7:0] ones;
        int s, sa, sb, ss;
        ones = 8'hFF;
        case (sel[1:0])
            2'd0:    bv = 8'h00;
            2'd1:    bv = b;
            2'd2:    bv = ~b;
            default: bv = 8'hFF;
        endcase
        s  = int'(a) + int'(bv) + int'(cin);
        sa = $signed(a);
        sb = $signed(bv);
        ss = sa + sb + int'(cin);
        ov = 1'b0;
        co = 1'b0;
        r  = a;
        lat = 1;
        case (sel[3:2])
            2'd0: begin
                r  = s[7:0];
                co = (s > 255);
                ov = (ss > 127) || (ss < -128);
            end
            2'd1: begin
                case (sel[1:0])
                    2'd0:    r = a & b;
                    2'd1:    r = a | b;
                    2'd2:    r = a ^ b;
                    default: r = ~a;
                endcase
                co = (s > 255);
            end
            2'd2: begin
                lat = n + 1;
                if (n > 0) begin
                    case (sel[1:0])
                        2'd0:    r = a >> n;
                        2'd1:    r = $signed(a) >>> n;
                        2'd2:    r = (a >> n) | (a << (8 - n));
                        default: r = (a >> n) | (cin ? (ones << (8 - n)) : 8'h00);
                    endcase
                    co = a[n-1];
                end
            end
            default: begin
                lat = n + 1;
                if (n > 0) begin
                    case (sel[1:0])
                        2'd2:    r = (a << n) | (a >> (8 - n));
                        2'd3:    r = (a << n) | (cin ? (ones >> (8 - n)) : 8'h00);
                        default: r = a << n;
                    endcase
                    co = a[8-n];
                end
            end
        endcase
    endfunction

    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic cin, input logic [3:0] sel, input logic [2:0] sh,
                          input int stall);
        logic [7:0] er;
        logic ec, eo;
        int lat, n;
        model(a, b, cin, sel, int'(sh), er, ec, eo, lat);
        @(negedge clk);
        chk($sformatf("%s.in_ready_idle", tag), bus.in_ready, 1);
        bus.in_valid = 1'b1; bus.a = a; bus.b = b; bus.cin = cin; bus.sel = sel; bus.shamt = sh;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.a = 8'($urandom); bus.b = 8'($urandom); bus.cin = 1'($urandom);
        bus.sel = 4'($urandom); bus.shamt = 3'($urandom);
        n = 1;
        while (!bus.out_valid && n < 64) begin
            chk($sformatf("%s.busy", tag), bus.busy, 1);
            chk($sformatf("%s.in_ready_busy", tag), bus.in_ready, 0);
            @(negedge clk);
            n++;
        end
        chk($sformatf("%s.latency", tag), n, lat);
        chk($sformatf("%s.result", tag), bus.result, er);
        chk($sformatf("%s.cout", tag), bus.cout, ec);
        chk($sformatf("%s.overflow", tag), bus.overflow, eo);
        chk($sformatf("%s.zero", tag), bus.zero, (er == 8'h00));
        chk($sformatf("%s.in_ready_hold", tag), bus.in_ready, 0);
        for (int i = 0; i < stall; i++) begin
            bus.in_valid = (i == 2);
            @(negedge clk);
            chk($sformatf("%s.stall_valid", tag), bus.out_valid, 1);
            chk($sformatf("%s.stall_result", tag), bus.result, er);
            chk($sformatf("%s.stall_flags", tag), {bus.cout, bus.overflow, bus.zero},
                {ec, eo, (er == 8'h00)});
            chk($sformatf("%s.stall_in_ready", tag), bus.in_ready, 0);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk($sformatf("%s.post_out_valid", tag), bus.out_valid, 0);
        chk($sformatf("%s.post_in_ready", tag), bus.in_ready, 1);
        chk($sformatf("%s.post_busy", tag), bus.busy, 0);
        chk($sformatf("%s.post_result_held", tag), bus.result, er);
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.a = 8'h00; bus.b = 8'h00; bus.cin = 1'b0; bus.sel = 4'h0; bus.shamt = 3'd0;
        #2;
        chk("reset.outputs",
            {bus.in_ready, bus.out_valid, bus.busy, bus.cout, bus.zero, bus.overflow, bus.result},
            32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_op("add",   8'h7F, 8'h01, 1'b0, 4'b0001, 3'd0, 0);
        run_op("sub",   8'h05, 8'h05, 1'b1, 4'b0010, 3'd0, 0);
        run_op("not",   8'h0F, 8'h33, 1'b0, 4'b0111, 3'd0, 0);
        run_op("asr3",  8'h90, 8'h00, 1'b0, 4'b1001, 3'd3, 0);
        run_op("asr0",  8'h90, 8'h00, 1'b0, 4'b1001, 3'd0, 0);
        run_op("rol1",  8'h81, 8'h00, 1'b0, 4'b1110, 3'd1, 0);
        run_op("cinr7", 8'h00, 8'h00, 1'b1, 4'b1011, 3'd7, 0);
        run_op("bp",    8'hC3, 8'h5A, 1'b0, 4'b0110, 3'd0, 5);

        // Reset during the third SHIFT cycle of a 7-position shift
        @(negedge clk);
        bus.in_valid = 1'b1; bus.a = 8'hFF; bus.sel = 4'b1000; bus.shamt = 3'd7;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midreset.outputs",
            {bus.in_ready, bus.out_valid, bus.busy, bus.cout, bus.zero, bus.overflow, bus.result},
            32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("midreset.no_stale", bus.out_valid, 0);
            chk("midreset.idle", bus.in_ready, 1);
        end
        run_op("after_reset", 8'h12, 8'h34, 1'b1, 4'b0001, 3'd0, 1);

        for (int k = 0; k < 40; k++) begin
            run_op($sformatf("rnd%0d", k), 8'($urandom), 8'($urandom), 1'($urandom),
                   4'($urandom), 3'($urandom), int'($urandom_range(0, 2)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
